// File: rtl/selftest_pkg.sv
// Shared types and constants for the switch/LED self-test: FSM state encoding,
// pattern width, the all-pass LED code and the expected LED function.
package selftest_pkg;

  localparam int PAT_W = 8;
  localparam logic [PAT_W-1:0] PASS_LED = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // LED value a correct switch/LED block returns for switch pattern s.
  function automatic logic [PAT_W-1:0] expected_led(input logic [PAT_W-1:0] s);
    logic [PAT_W-1:0] e;
    e[0]   = ~s[0];
    e[1]   = s[1] & ~s[2];
    e[3]   = ~s[2] & s[3];
    e[2]   = e[1] | e[3];
    e[7:4] = s[7:4];
    return e;
  endfunction

endpackage

// File: rtl/selftest_settle_timer.sv
// Settle-time down counter: load arms it, then `expired` is high in the
// CYCLES-th enabled cycle after the load.
module selftest_settle_timer #(
  parameter int unsigned CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= 8'(CYCLES - 1);
    end else if (enable && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expired = enable && (count == 8'd0);

endmodule

// File: rtl/switch_led_selftest.sv
// Self-test sequencer for the board switch/LED logic: sweeps switch patterns,
// compares LEDs against the expected function and reports pass/err/first fail.
// Optional macro SELFTEST_STOP_ON_FAIL_EN ends the run at the first mismatch.
//
// Handshake: start is a one-cycle request, accepted only in IDLE or DONE;
// busy is high for the whole run, done holds the result until the next
// accepted start or reset.
module switch_led_selftest
  import selftest_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned PAT_STEP      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] sw_in,
  output logic [PAT_W-1:0] sw_out,
  input  logic [PAT_W-1:0] led_in,
  output logic [PAT_W-1:0] led_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [PAT_W-1:0] fail_pattern,
  output state_t           state_dbg
);

  state_t           state, next_state;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W:0]   pat_sum;
  logic             mismatch;
  logic             start_run;
  logic             settle_expired;

  assign pat_sum   = {1'b0, pattern} + 9'(PAT_STEP);
  assign mismatch  = (led_in != expected_led(pattern));
  assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign state_dbg = state;

  selftest_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (state == ST_APPLY),
    .enable  (state == ST_SETTLE),
    .expired (settle_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_APPLY;
      ST_APPLY:         next_state = ST_SETTLE;
      ST_SETTLE:        if (settle_expired) next_state = ST_CHECK;
      ST_CHECK: begin
`ifdef SELFTEST_STOP_ON_FAIL_EN
        if (mismatch || pat_sum[PAT_W]) next_state = ST_DONE;
        else                            next_state = ST_APPLY;
`else
        if (pat_sum[PAT_W]) next_state = ST_DONE;
        else                next_state = ST_APPLY;
`endif
      end
      default:          next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    sw_out  = sw_in;
    led_out = led_in;
    unique case (state)
      ST_APPLY, ST_SETTLE, ST_CHECK: begin
        busy   = 1'b1;
        sw_out = pattern;
      end
      ST_DONE: begin
        done    = 1'b1;
        led_out = pass ? PASS_LED : err_count;
      end
      default: ;
    endcase
  end

  // Result datapath; pass is frozen on the CHECK that leads into DONE.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      pattern      <= '0;
      err_count    <= 8'd0;
      fail_pattern <= '0;
      pass         <= 1'b0;
    end else if (state == ST_CHECK) begin
      if (mismatch) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0)  fail_pattern <= pattern;
      end
      pattern <= pat_sum[PAT_W-1:0];
      if (next_state == ST_DONE) pass <= (err_count == 8'd0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_switch_led_selftest.sv
// Bench for switch_led_selftest: table-driven IDLE pass-through vectors,
// directed full runs and random stuck-at LED faults against a sweep model.
module tb_switch_led_selftest;
  import selftest_pkg::*;

  localparam int SETTLE = 10;
  localparam int STEP   = 2;
`ifdef SELFTEST_STOP_ON_FAIL_EN
  localparam logic [7:0] RST_MASK = 8'h00;
`else
  localparam logic [7:0] RST_MASK = 8'h04;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] sw_in, sw_out, led_in, led_out, err_count, fail_pattern;
  logic       busy, done, pass;
  state_t     state_dbg;

  logic       bypass;
  logic [7:0] led_direct, stuck0, stuck1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_led_selftest #(.SETTLE_CYCLES(SETTLE), .PAT_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .sw_in(sw_in), .sw_out(sw_out),
    .led_in(led_in), .led_out(led_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_pattern(fail_pattern), .state_dbg(state_dbg)
  );

  // LED rules evaluated bit by bit from integer arithmetic.
  function automatic logic [7:0] led_rule(input int s);
    int r;
    int s1, s2, s3;
    s1 = (s >> 1) & 1;
    s2 = (s >> 2) & 1;
    s3 = (s >> 3) & 1;
    r  = s & 'hF0;
    if ((s & 1) == 0) r += 1;
    if (s1 == 1 && s2 == 0) r += 2;
    if (s3 == 1 && s2 == 0) r += 8;
    if (s2 == 0 && (s1 + s3) > 0) r += 4;
    return 8'(r);
  endfunction

  // Board model: correct LED logic with optional stuck-at faults.
  always_comb begin
    led_in = bypass ? led_direct : ((led_rule(int'(sw_out)) & ~stuck0) | stuck1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-sweep model: which patterns are visited, how long, what fails.
  task automatic model_run(input logic [7:0] s0, input logic [7:0] s1,
                           output int cyc, output int errs, output int first);
    logic [7:0] got;
    cyc = 0; errs = 0; first = 0;
    for (int p = 0; p < 256; p += STEP) begin
      cyc += SETTLE + 2;
      got = (led_rule(p) & ~s0) | s1;
      if (got != led_rule(p)) begin
        if (errs == 0) first = p;
        if (errs < 255) errs++;
`ifdef SELFTEST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input int repulse_at);
    int exp_cyc, exp_err, exp_first, cyc;
    bit busy_ok, sw_ok;
    stuck0 = s0; stuck1 = s1; bypass = 1'b0;
    model_run(s0, s1, exp_cyc, exp_err, exp_first);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; busy_ok = 1'b1; sw_ok = 1'b1;
    while (!done && cyc < 4000) begin
      if (!busy) busy_ok = 1'b0;
      if (sw_out !== 8'((cyc / (SETTLE + 2)) * STEP)) sw_ok = 1'b0;
      if (cyc == repulse_at) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc++;
    end
    $display("run %s: %0d cycles, err_count %0d", tag, cyc, err_count);
    check({tag, "_done"},      32'(done),         32'd1);
    check({tag, "_cycles"},    32'(cyc),          32'(exp_cyc));
    check({tag, "_busy_run"},  32'(busy_ok),      32'd1);
    check({tag, "_sw_seq"},    32'(sw_ok),        32'd1);
    check({tag, "_busy_end"},  32'(busy),         32'd0);
    check({tag, "_pass"},      32'(pass),         32'(exp_err == 0));
    check({tag, "_err_count"}, 32'(err_count),    32'(exp_err));
    check({tag, "_fail_pat"},  32'(fail_pattern), 32'(exp_first));
    check({tag, "_led_out"},   32'(led_out),      (exp_err == 0) ? 32'hFF : 32'(exp_err));
  endtask

  typedef struct {
    logic [7:0] sw;
    logic [7:0] led;
    logic [7:0] exp_sw;
    logic [7:0] exp_led;
  } idle_vec_t;

  idle_vec_t vecs[4];

  initial begin
    int cyc;
    logic [7:0] r_sw, r_led, m0, m1;
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81};

    reset = 1'b1; start = 1'b0; sw_in = 8'h00;
    bypass = 1'b1; led_direct = 8'h00; stuck0 = 8'h00; stuck1 = 8'h00;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    sw_in = 8'h12; led_direct = 8'h34;
    #1;
    check("rst_busy",   32'(busy),         32'd0);
    check("rst_done",   32'(done),         32'd0);
    check("rst_pass",   32'(pass),         32'd0);
    check("rst_err",    32'(err_count),    32'd0);
    check("rst_fail",   32'(fail_pattern), 32'd0);
    check("rst_sw_out", 32'(sw_out),       32'h12);
    check("rst_led",    32'(led_out),      32'h34);

    foreach (vecs[i]) begin
      @(negedge clk);
      sw_in = vecs[i].sw; led_direct = vecs[i].led;
      #1;
      check($sformatf("idle_sw_%0d", i),  32'(sw_out),  32'(vecs[i].exp_sw));
      check($sformatf("idle_led_%0d", i), 32'(led_out), 32'(vecs[i].exp_led));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r_sw = 8'($urandom_range(0, 255)); r_led = 8'($urandom_range(0, 255));
      sw_in = r_sw; led_direct = r_led;
      #1;
      check("idle_rand_sw",  32'(sw_out),  32'(r_sw));
      check("idle_rand_led", 32'(led_out), 32'(r_led));
    end

    run_check("clean", 8'h00, 8'h00, -1);
    @(negedge clk); sw_in = 8'h77; #1;
    check("done_sw_out", 32'(sw_out), 32'h77);

    run_check("ld2_stuck0", 8'h04, 8'h00, -1);
    run_check("restart_ignored", 8'h00, 8'h00, 100);

    // Reset during SETTLE of pattern 40 must abort cleanly.
    stuck0 = RST_MASK; stuck1 = 8'h00; bypass = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (cyc < 245) begin
      @(posedge clk); #1; cyc++;
    end
    check("mid_sw_out", 32'(sw_out), 32'd40);
    sw_in = 8'h5A; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy),         32'd0);
    check("mid_rst_done", 32'(done),         32'd0);
    check("mid_rst_err",  32'(err_count),    32'd0);
    check("mid_rst_fail", 32'(fail_pattern), 32'd0);
    check("mid_rst_sw",   32'(sw_out),       32'h5A);
    check("mid_rst_led",  32'(led_out),      32'(led_rule(32'h5A) & ~RST_MASK));
    run_check("after_reset", 8'h00, 8'h00, -1);

    for (int i = 0; i < 3; i++) begin
      m0 = 8'($urandom & $urandom);
      m1 = 8'($urandom & $urandom) & ~m0;
      run_check($sformatf("rand%0d", i), m0, m1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
